// File: rtl/writeback_unit_if.sv
// Instruction handshake and load-data bus between the MEM stage and the writeback unit.
// The MEM side drives the instruction fields and load data; the unit returns in_ready.
interface writeback_unit_if #(
    parameter int XLEN = 32,
    parameter int RA   = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [3:0]      in_wb_sel;
    logic [RA-1:0]   in_wb_addr;
    logic            in_rf_wen;
    logic [2:0]      in_csr_cmd;
    logic            in_jmp_flg;
    logic            in_br_flg;
    logic [XLEN-1:0] in_br_target;
    logic [XLEN-1:0] in_alu_out;
    logic [XLEN-1:0] in_csr_rdata;
    logic [XLEN-1:0] in_trap_vector;
    logic            mem_rdata_valid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output in_valid, in_pc, in_wb_sel, in_wb_addr, in_rf_wen, in_csr_cmd,
               in_jmp_flg, in_br_flg, in_br_target, in_alu_out, in_csr_rdata,
               in_trap_vector, mem_rdata_valid, mem_rdata,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_wb_sel, in_wb_addr, in_rf_wen, in_csr_cmd,
               in_jmp_flg, in_br_flg, in_br_target, in_alu_out, in_csr_rdata,
               in_trap_vector, mem_rdata_valid, mem_rdata,
        output in_ready
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: integer register file with bypassing read ports, load stall,
// registered PC redirects, retired-instruction counter and sticky exit flag.
module writeback_unit #(
    parameter int              XLEN      = 32,
    parameter int              NREG      = 32,
    parameter logic [XLEN-1:0] REG_RESET = '1,
    parameter int              SP_IDX    = 2,
    parameter logic [31:0]     SP_RESET  = 32'h0000_0800,
    parameter logic [31:0]     EXIT_PC   = 32'hffff_ff00,
    parameter logic [XLEN-1:0] BUBBLE_PC = '1,
    localparam int             RA        = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    writeback_unit_if.slave  bus,
    input  logic [RA-1:0]    rs1_addr,
    input  logic [RA-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             retire_valid,
    output logic [63:0]      instret,
    output logic             exit
);

    localparam logic [3:0] WB_X     = 4'd0;
    localparam logic [3:0] WB_ALU   = 4'd1;
    localparam logic [3:0] WB_MEMB  = 4'd2;
    localparam logic [3:0] WB_MEMBU = 4'd3;
    localparam logic [3:0] WB_MEMH  = 4'd4;
    localparam logic [3:0] WB_MEMHU = 4'd5;
    localparam logic [3:0] WB_MEMW  = 4'd6;
    localparam logic [3:0] WB_PC    = 4'd7;
    localparam logic [3:0] WB_CSR   = 4'd8;

    localparam logic [2:0] CSR_ECALL = 3'd4;

    localparam logic [XLEN-1:0] SP_RESET_X = XLEN'(SP_RESET);
    localparam logic [XLEN-1:0] EXIT_PC_X  = XLEN'(EXIT_PC);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      wb_sel;
        logic [RA-1:0]   wb_addr;
        logic            rf_wen;
        logic [2:0]      csr_cmd;
        logic            jmp_flg;
        logic            br_flg;
        logic [XLEN-1:0] br_target;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] csr_rdata;
        logic [XLEN-1:0] trap_vector;
    } instr_t;

    function automatic logic is_load(input logic [3:0] sel);
        return (sel == WB_MEMB) || (sel == WB_MEMBU) || (sel == WB_MEMH) ||
               (sel == WB_MEMHU) || (sel == WB_MEMW);
    endfunction

    state_t          state, state_next;
    instr_t          in_ins, held, cur;
    logic            in_ready_c;
    logic            complete;
    logic            go_wait;
    logic            exit_hit;
    logic            do_redirect;
    logic            rf_we;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] regs [NREG];

    assign in_ins = '{
        pc:          bus.in_pc,
        wb_sel:      bus.in_wb_sel,
        wb_addr:     bus.in_wb_addr,
        rf_wen:      bus.in_rf_wen,
        csr_cmd:     bus.in_csr_cmd,
        jmp_flg:     bus.in_jmp_flg,
        br_flg:      bus.in_br_flg,
        br_target:   bus.in_br_target,
        alu_out:     bus.in_alu_out,
        csr_rdata:   bus.in_csr_rdata,
        trap_vector: bus.in_trap_vector
    };

    // While waiting on load data the latched instruction is the one being completed.
    assign cur         = (state == S_WAIT) ? held : in_ins;
    assign exit_hit    = (cur.pc == EXIT_PC_X);
    assign do_redirect = cur.br_flg | cur.jmp_flg | (cur.csr_cmd == CSR_ECALL);
    assign rf_we       = complete && cur.rf_wen && (cur.wb_addr != '0);
    assign bus.in_ready = in_ready_c;

    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        complete   = 1'b0;
        go_wait    = 1'b0;
        case (state)
            S_RUN: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    if (is_load(in_ins.wb_sel) && !bus.mem_rdata_valid) begin
                        go_wait    = 1'b1;
                        state_next = S_WAIT;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.mem_rdata_valid) begin
                    complete   = 1'b1;
                    state_next = S_RUN;
                end
            end
            default: ;
        endcase
        if (complete && exit_hit) state_next = S_HALT;
        if (rst) begin
            complete = 1'b0;
            go_wait  = 1'b0;
        end
    end

    always_comb begin
        wb_data = cur.alu_out;
        case (cur.wb_sel)
            WB_MEMB:  wb_data = XLEN'($signed(bus.mem_rdata[7:0]));
            WB_MEMBU: wb_data = XLEN'(bus.mem_rdata[7:0]);
            WB_MEMH:  wb_data = XLEN'($signed(bus.mem_rdata[15:0]));
            WB_MEMHU: wb_data = XLEN'(bus.mem_rdata[15:0]);
            WB_MEMW:  wb_data = XLEN'($signed(bus.mem_rdata[31:0]));
            WB_PC:    wb_data = cur.pc + XLEN'(4);
            WB_CSR:   wb_data = cur.csr_rdata;
            WB_X, WB_ALU: wb_data = cur.alu_out;
            default:  wb_data = cur.alu_out;
        endcase
    end

    always_comb begin
        redir_tgt = cur.trap_vector;
        if (cur.br_flg)       redir_tgt = cur.br_target;
        else if (cur.jmp_flg) redir_tgt = cur.alu_out;
    end

    // NOTE: the register file is reset explicitly because every register has a defined reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == SP_IDX) ? SP_RESET_X : REG_RESET;
        end else if (rf_we) begin
            regs[cur.wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == '0)                        rs1_data = '0;
        else if (rf_we && cur.wb_addr == rs1_addr) rs1_data = wb_data;
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == '0)                        rs2_data = '0;
        else if (rf_we && cur.wb_addr == rs2_addr) rs2_data = wb_data;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            held           <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            retire_valid   <= 1'b0;
            instret        <= '0;
            exit           <= 1'b0;
        end else begin
            if (go_wait) held <= in_ins;
            redirect_valid <= complete && do_redirect;
            if (complete && do_redirect) redirect_pc <= redir_tgt;
            retire_valid <= complete && (cur.pc != BUBBLE_PC);
            if (complete && (cur.pc != BUBBLE_PC)) instret <= instret + 64'd1;
            if (complete && exit_hit) exit <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a scoreboard
// of expected retire/redirect pulses consumed by a monitor.
module tb_writeback_unit;

    localparam logic [3:0] WB_ALU   = 4'd1;
    localparam logic [3:0] WB_MEMB  = 4'd2;
    localparam logic [3:0] WB_MEMBU = 4'd3;
    localparam logic [3:0] WB_MEMH  = 4'd4;
    localparam logic [3:0] WB_MEMHU = 4'd5;
    localparam logic [3:0] WB_MEMW  = 4'd6;
    localparam logic [3:0] WB_PC    = 4'd7;
    localparam logic [3:0] WB_CSR   = 4'd8;
    localparam logic [2:0] CSR_ECALL = 3'd4;

    typedef struct {
        logic        retire;
        logic        redir;
        logic [31:0] rpc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        redirect_valid, retire_valid, exit_flag;
    logic [31:0] redirect_pc;
    logic [63:0] instret;

    logic [4:0]  rs1_addr64, rs2_addr64;
    logic [63:0] rs1_data64, rs2_data64;
    logic        redirect_valid64, retire_valid64, exit_flag64;
    logic [63:0] redirect_pc64;
    logic [63:0] instret64;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_instret = '0;
    ev_t         exp_q[$];

    writeback_unit_if #(.XLEN(32), .RA(5)) b32 ();
    writeback_unit_if #(.XLEN(64), .RA(5)) b64 ();

    writeback_unit #(.XLEN(32)) u_dut (
        .clk(clk), .rst(rst), .bus(b32),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .retire_valid(retire_valid), .instret(instret), .exit(exit_flag)
    );

    writeback_unit #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .bus(b64),
        .rs1_addr(rs1_addr64), .rs2_addr(rs2_addr64),
        .rs1_data(rs1_data64), .rs2_data(rs2_data64),
        .redirect_valid(redirect_valid64), .redirect_pc(redirect_pc64),
        .retire_valid(retire_valid64), .instret(instret64), .exit(exit_flag64)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every retire/redirect pulse must match the oldest expectation.
    always @(negedge clk) begin
        ev_t e;
        if (!rst && (retire_valid || redirect_valid)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor_unexpected retire=%0b redirect=%0b pc=%h expected no pulse",
                         retire_valid, redirect_valid, redirect_pc);
            end else begin
                e = exp_q.pop_front();
                if (retire_valid !== e.retire || redirect_valid !== e.redir ||
                    (e.redir && redirect_pc !== e.rpc)) begin
                    errors++;
                    $display("FAIL monitor_event got retire=%0b redir=%0b pc=%h want retire=%0b redir=%0b pc=%h",
                             retire_valid, redirect_valid, redirect_pc, e.retire, e.redir, e.rpc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b32.in_valid = 1'b0;   b32.in_pc = '0;        b32.in_wb_sel = WB_ALU;
        b32.in_wb_addr = '0;   b32.in_rf_wen = 1'b0;  b32.in_csr_cmd = '0;
        b32.in_jmp_flg = 1'b0; b32.in_br_flg = 1'b0;  b32.in_br_target = '0;
        b32.in_alu_out = '0;   b32.in_csr_rdata = '0; b32.in_trap_vector = '0;
        b32.mem_rdata_valid = 1'b0; b32.mem_rdata = '0;
    endtask

    task automatic idle64();
        b64.in_valid = 1'b0;   b64.in_pc = '0;        b64.in_wb_sel = WB_ALU;
        b64.in_wb_addr = '0;   b64.in_rf_wen = 1'b0;  b64.in_csr_cmd = '0;
        b64.in_jmp_flg = 1'b0; b64.in_br_flg = 1'b0;  b64.in_br_target = '0;
        b64.in_alu_out = '0;   b64.in_csr_rdata = '0; b64.in_trap_vector = '0;
        b64.mem_rdata_valid = 1'b0; b64.mem_rdata = '0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [3:0] sel, input logic [4:0] addr,
                         input logic wen, input logic [31:0] alu);
        idle();
        b32.in_valid = 1'b1; b32.in_pc = pc; b32.in_wb_sel = sel;
        b32.in_wb_addr = addr; b32.in_rf_wen = wen; b32.in_alu_out = alu;
    endtask

    task automatic push_ev(input logic retire, input logic redir, input logic [31:0] rpc);
        ev_t e;
        e.retire = retire; e.redir = redir; e.rpc = rpc;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        rs1_addr = 5'd2; rs2_addr = 5'd5;
        #1;
        checks++; if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", b32.in_ready); end
        checks++; if (retire_valid !== 1'b0 || redirect_valid !== 1'b0 || exit_flag !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ret=%b red=%b exit=%b want 0", retire_valid, redirect_valid, exit_flag); end
        checks++; if (redirect_pc !== 32'h0 || instret !== 64'h0) begin
            errors++; $display("FAIL reset_regs got rpc=%h instret=%0d want 0", redirect_pc, instret); end
        checks++; if (rs1_data !== 32'h0000_0800) begin errors++; $display("FAIL reset_sp got %h want 00000800", rs1_data); end
        checks++; if (rs2_data !== 32'hffff_ffff) begin errors++; $display("FAIL reset_x5 got %h want ffffffff", rs2_data); end
        rs1_addr = 5'd0;
        #1;
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL reset_x0 got %h want 0", rs1_data); end
    endtask

    task automatic test_alu_write();
        issue(32'h100, WB_ALU, 5'd5, 1'b1, 32'h1234);
        rs1_addr = 5'd5;
        push_ev(1'b1, 1'b0, '0);
        exp_instret++;
        #1;
        checks++; if (rs1_data !== 32'h1234) begin errors++; $display("FAIL alu_bypass got %h want 00001234", rs1_data); end
        step();
        idle();
        #1;
        checks++; if (rs1_data !== 32'h1234) begin errors++; $display("FAIL alu_reg got %h want 00001234", rs1_data); end
        checks++; if (retire_valid !== 1'b1 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL alu_pulses got ret=%b red=%b want 1/0", retire_valid, redirect_valid); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL alu_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_load_wait();
        issue(32'h104, WB_MEMB, 5'd6, 1'b1, 32'h0);
        rs1_addr = 5'd6; rs2_addr = 5'd7;
        step();
        for (int i = 0; i < 3; i++) begin
            // A competing instruction is presented while stalled and must be ignored.
            issue(32'h500, WB_ALU, 5'd7, 1'b1, 32'h0bad);
            #1;
            checks++; if (b32.in_ready !== 1'b0) begin errors++; $display("FAIL wait_ready[%0d] got %b want 0", i, b32.in_ready); end
            checks++; if (rs1_data !== 32'hffff_ffff) begin errors++; $display("FAIL wait_x6[%0d] got %h want ffffffff", i, rs1_data); end
            step();
        end
        b32.mem_rdata_valid = 1'b1;
        b32.mem_rdata = 32'h0000_0080;
        push_ev(1'b1, 1'b0, '0);
        exp_instret++;
        #1;
        checks++; if (rs1_data !== 32'hffff_ff80) begin errors++; $display("FAIL load_bypass got %h want ffffff80", rs1_data); end
        step();
        idle();
        #1;
        checks++; if (rs1_data !== 32'hffff_ff80) begin errors++; $display("FAIL load_x6 got %h want ffffff80", rs1_data); end
        checks++; if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b want 1", b32.in_ready); end
        checks++; if (rs2_data !== 32'hffff_ffff) begin errors++; $display("FAIL load_x7_ignored got %h want ffffffff", rs2_data); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL load_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  sel  [7] = '{WB_MEMBU, WB_MEMH, WB_MEMHU, WB_MEMW, WB_PC, WB_CSR, WB_MEMB};
        logic [31:0] data [7] = '{32'h80, 32'h8000, 32'h1_8000, 32'hdead_beef, 32'h0, 32'h0, 32'h7f};
        logic [31:0] csr  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h55, 32'h0};
        logic [31:0] want [7] = '{32'h80, 32'hffff_8000, 32'h8000, 32'hdead_beef, 32'h204, 32'h55, 32'h7f};
        for (int i = 0; i < 7; i++) begin
            issue(32'h1f0 + 32'(i) * 32'h10, sel[i], 5'(13 + i), 1'b1, 32'h0);
            if (sel[i] == WB_PC) b32.in_pc = 32'h200;
            b32.in_csr_rdata = csr[i];
            b32.mem_rdata_valid = 1'b1;
            b32.mem_rdata = data[i];
            rs1_addr = 5'(13 + i);
            rs2_addr = 5'(13 + i);
            push_ev(1'b1, 1'b0, '0);
            exp_instret++;
            #1;
            checks++; if (rs1_data !== want[i]) begin errors++; $display("FAIL b2b_bypass[%0d] got %h want %h", i, rs1_data, want[i]); end
            step();
            b32.in_valid = 1'b0;
            #1;
            checks++; if (rs2_data !== want[i]) begin errors++; $display("FAIL b2b_reg[%0d] got %h want %h", i, rs2_data, want[i]); end
        end
        idle();
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL b2b_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_redirect();
        logic [2:0]  mode [3] = '{3'b111, 3'b001, 3'b010};   // {br, jmp, ecall}
        logic [31:0] want [3] = '{32'h200, 32'h300, 32'h250};
        for (int i = 0; i < 3; i++) begin
            issue(32'h140 + 32'(i) * 4, WB_ALU, 5'd0, 1'b0, 32'h250);
            b32.in_br_flg  = mode[i][2];
            b32.in_jmp_flg = mode[i][1];
            b32.in_csr_cmd = mode[i][0] ? CSR_ECALL : 3'd0;
            b32.in_br_target = 32'h200;
            b32.in_trap_vector = 32'h300;
            push_ev(1'b1, 1'b1, want[i]);
            exp_instret++;
            step();
            idle();
            checks++; if (redirect_valid !== 1'b1 || redirect_pc !== want[i]) begin
                errors++; $display("FAIL redirect[%0d] got v=%b pc=%h want 1 %h", i, redirect_valid, redirect_pc, want[i]); end
            step();
            checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL redirect_pulse[%0d] got %b want 0", i, redirect_valid); end
        end
    endtask

    task automatic test_x0_bubble();
        issue(32'h180, WB_ALU, 5'd0, 1'b1, 32'hAA);
        rs1_addr = 5'd0;
        push_ev(1'b1, 1'b0, '0);
        exp_instret++;
        #1;
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_bypass got %h want 0", rs1_data); end
        step();
        idle();
        #1;
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_reg got %h want 0", rs1_data); end
        issue(32'hffff_ffff, WB_ALU, 5'd9, 1'b0, 32'h77);
        step();
        idle();
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL bubble_retire got %b want 0", retire_valid); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL bubble_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_exit();
        issue(32'hffff_ff00, WB_ALU, 5'd0, 1'b0, 32'h0);
        push_ev(1'b1, 1'b0, '0);
        exp_instret++;
        step();
        idle();
        checks++; if (exit_flag !== 1'b1 || b32.in_ready !== 1'b0) begin
            errors++; $display("FAIL exit_set got exit=%b ready=%b want 1/0", exit_flag, b32.in_ready); end
        issue(32'h1c0, WB_ALU, 5'd10, 1'b1, 32'h99);
        rs1_addr = 5'd10;
        step(); step();
        idle();
        #1;
        checks++; if (rs1_data !== 32'hffff_ffff || b32.in_ready !== 1'b0 || exit_flag !== 1'b1) begin
            errors++; $display("FAIL halt_hold got x10=%h ready=%b exit=%b want ffffffff/0/1", rs1_data, b32.in_ready, exit_flag); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL halt_instret got %0d want %0d", instret, exp_instret); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_instret = '0;
        #1;
        checks++; if (exit_flag !== 1'b0 || b32.in_ready !== 1'b1 || instret !== 64'h0) begin
            errors++; $display("FAIL exit_clear got exit=%b ready=%b instret=%0d want 0/1/0", exit_flag, b32.in_ready, instret); end
    endtask

    task automatic test_reset_wait();
        issue(32'h1d0, WB_MEMW, 5'd11, 1'b1, 32'h0);
        rs1_addr = 5'd11;
        step();
        idle();
        #1;
        checks++; if (b32.in_ready !== 1'b0) begin errors++; $display("FAIL rstwait_ready got %b want 0", b32.in_ready); end
        rst = 1'b1;
        b32.mem_rdata_valid = 1'b1;
        b32.mem_rdata = 32'h1234;
        step();
        rst = 1'b0;
        idle();
        #1;
        checks++; if (rs1_data !== 32'hffff_ffff || instret !== 64'h0 || retire_valid !== 1'b0) begin
            errors++; $display("FAIL rstwait_discard got x11=%h instret=%0d ret=%b want ffffffff/0/0", rs1_data, instret, retire_valid); end
        checks++; if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL rstwait_run got %b want 1", b32.in_ready); end
    endtask

    task automatic test_xlen64();
        idle64();
        b64.in_valid = 1'b1; b64.in_pc = 64'h300; b64.in_wb_sel = WB_MEMW;
        b64.in_wb_addr = 5'd12; b64.in_rf_wen = 1'b1;
        b64.mem_rdata_valid = 1'b1; b64.mem_rdata = 64'h8000_0000;
        rs1_addr64 = 5'd12; rs2_addr64 = 5'd12;
        #1;
        checks++; if (rs1_data64 !== 64'hffff_ffff_8000_0000) begin
            errors++; $display("FAIL x64_bypass got %h want ffffffff80000000", rs1_data64); end
        step();
        idle64();
        #1;
        checks++; if (rs2_data64 !== 64'hffff_ffff_8000_0000) begin
            errors++; $display("FAIL x64_reg got %h want ffffffff80000000", rs2_data64); end
        checks++; if (retire_valid64 !== 1'b1 || instret64 !== 64'd1) begin
            errors++; $display("FAIL x64_retire got ret=%b instret=%0d want 1/1", retire_valid64, instret64); end
    endtask

    initial begin
        idle();
        idle64();
        rs1_addr = '0; rs2_addr = '0; rs1_addr64 = '0; rs2_addr64 = '0;
        test_reset();
        test_alu_write();
        test_load_wait();
        test_back_to_back();
        test_redirect();
        test_x0_bubble();
        test_exit();
        test_reset_wait();
        test_xlen64();
        step(); step();
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
